// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle stage sequencer.
// - state_e: FSM states, encoded so that each value equals the reported stage number.
// - op_class_e: decoder instruction classes (codes 5..7 are illegal).
// - StageNum*: stage_num encodings.
// - is_illegal(): true for an undefined class code.
package seq_pkg;

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    OpAlu    = 3'd0,
    OpLoad   = 3'd1,
    OpStore  = 3'd2,
    OpBranch = 3'd3,
    OpJump   = 3'd4
  } op_class_e;

  localparam logic [2:0] StageNumIf   = 3'd0;
  localparam logic [2:0] StageNumId   = 3'd1;
  localparam logic [2:0] StageNumEx   = 3'd2;
  localparam logic [2:0] StageNumMem  = 3'd3;
  localparam logic [2:0] StageNumWb   = 3'd4;
  localparam logic [2:0] StageNumHalt = 3'd7;

  function automatic logic is_illegal(input logic [2:0] op);
    return op > 3'd4;
  endfunction

endpackage

// File: rtl/multicycle_stage_sequencer_if.sv
// Bundle of the sequencer's control-side signals.
// master: the sequencer (consumes decoder/memory status, drives enables and status).
// slave:  the surrounding datapath/control that drives the inputs and observes the outputs.
// Signals:
//   op_class            decoder instruction class, valid during ID
//   imem_ready          instruction fetch data valid
//   dmem_ready          data access complete
//   stall               freeze request
//   halt_req            stop at the next instruction boundary
//   en_if..en_wb        one-hot stage enables
//   stage_num           current stage (7 = halted)
//   pc_wr, retire       final cycle of an instruction
//   illegal             illegal class seen in ID
//   bus_err             sticky memory timeout flag
//   halted              sequencer in HALT
//   instr_count         retired instruction count
interface multicycle_stage_sequencer_if #(
  parameter int unsigned CNT_W = 32
);

  logic [2:0]       op_class;
  logic             imem_ready;
  logic             dmem_ready;
  logic             stall;
  logic             halt_req;
  logic             en_if;
  logic             en_id;
  logic             en_ex;
  logic             en_mem;
  logic             en_wb;
  logic [2:0]       stage_num;
  logic             pc_wr;
  logic             retire;
  logic             illegal;
  logic             bus_err;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  op_class, imem_ready, dmem_ready, stall, halt_req,
    output en_if, en_id, en_ex, en_mem, en_wb, stage_num, pc_wr, retire, illegal,
    output bus_err, halted, instr_count
  );

  modport slave (
    output op_class, imem_ready, dmem_ready, stall, halt_req,
    input  en_if, en_id, en_ex, en_mem, en_wb, stage_num, pc_wr, retire, illegal,
    input  bus_err, halted, instr_count
  );

endinterface

// File: rtl/seq_wait_timer.sv
// Memory wait-state counter with timeout compare.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clear     restart from zero (stage change)
//   count     one more not-ready cycle
//   hold      freeze the counter (has priority over clear/count)
//   expired   counter has reached TIMEOUT (never asserted when TIMEOUT is 0)
module seq_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  input  logic hold,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (hold) begin
      cnt_d = cnt_q;
    end else if (clear) begin
      cnt_d = '0;
    end else if (count && !expired) begin
      // Saturates at TIMEOUT; the FSM leaves the stage on that cycle anyway.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_stage_sequencer.sv
// Stage sequencer for the multi-cycle datapath. Walks each instruction through
// IF/ID/EX/MEM/WB, skipping stages by instruction class, stretching IF and MEM for
// memory wait states and halting on a wait timeout or a boundary halt request.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       control interface (master side), see multicycle_stage_sequencer_if
// Parameters:
//   TIMEOUT   max consecutive not-ready cycles in IF/MEM before bus error (0 = off)
//   CNT_W     retired-instruction counter width
module multicycle_stage_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_stage_sequencer_if.master   bus
);

  state_e           state_q, state_d;
  logic [2:0]       cls_q, cls_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             berr_q, berr_d;

  logic active;
  logic waiting;
  logic complete;
  logic last_stage;
  logic expired;
  logic timeout;

  // Outputs that cause side effects are suppressed during reset and stall.
  assign active = !rst && !bus.stall;

  // Stage completion and end-of-instruction decode.
  always_comb begin
    waiting    = 1'b0;
    complete   = 1'b0;
    last_stage = 1'b0;
    unique case (state_q)
      StIf: begin
        waiting  = !bus.imem_ready;
        complete = bus.imem_ready;
      end
      StId: begin
        complete   = 1'b1;
        // cls_q is not loaded yet, so the live decoder class decides here.
        last_stage = (bus.op_class == OpJump) || is_illegal(bus.op_class);
      end
      StEx: begin
        complete   = 1'b1;
        last_stage = !(cls_q inside {OpAlu, OpLoad, OpStore});
      end
      StMem: begin
        waiting    = !bus.dmem_ready;
        complete   = bus.dmem_ready;
        last_stage = (cls_q != OpLoad);
      end
      StWb: begin
        complete   = 1'b1;
        last_stage = 1'b1;
      end
      default: begin
        waiting    = 1'b0;
        complete   = 1'b0;
        last_stage = 1'b0;
      end
    endcase
  end

  assign timeout = waiting && expired;

  // Next-state logic; stall freezes everything, timeout beats normal progress.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    count_d = count_q;
    berr_d  = berr_q;
    if (!bus.stall) begin
      if (timeout) begin
        state_d = StHalt;
        berr_d  = 1'b1;
      end else if (complete) begin
        if (state_q == StId) begin
          cls_d = bus.op_class;
        end
        if (last_stage) begin
          count_d = count_q + CNT_W'(1);
          if (bus.halt_req) begin
            state_d = StHalt;
          end else begin
            state_d = StIf;
          end
        end else begin
          unique case (state_q)
            StIf:  state_d = StId;
            StId:  state_d = StEx;
            StEx: begin
              if (cls_q == OpAlu) begin
                state_d = StWb;
              end else begin
                state_d = StMem;
              end
            end
            StMem: state_d = StWb;
            default: state_d = state_q;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIf;
      cls_q   <= '0;
      count_q <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      count_q <= count_d;
      berr_q  <= berr_d;
    end
  end

  seq_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .count   (waiting),
    .hold    (bus.stall),
    .expired (expired)
  );

  // Moore decode of the state.
  always_comb begin
    bus.stage_num = StageNumHalt;
    unique case (state_q)
      StIf:    bus.stage_num = StageNumIf;
      StId:    bus.stage_num = StageNumId;
      StEx:    bus.stage_num = StageNumEx;
      StMem:   bus.stage_num = StageNumMem;
      StWb:    bus.stage_num = StageNumWb;
      default: bus.stage_num = StageNumHalt;
    endcase
  end

  assign bus.en_if       = active && (state_q == StIf);
  assign bus.en_id       = active && (state_q == StId);
  assign bus.en_ex       = active && (state_q == StEx);
  assign bus.en_mem      = active && (state_q == StMem);
  assign bus.en_wb       = active && (state_q == StWb);
  assign bus.pc_wr       = active && complete && last_stage;
  assign bus.retire      = active && complete && last_stage;
  assign bus.illegal     = active && (state_q == StId) && is_illegal(bus.op_class);
  assign bus.bus_err     = berr_q;
  assign bus.halted      = (state_q == StHalt);
  assign bus.instr_count = count_q;

endmodule

// File: doc/multicycle_stage_sequencer.md
# multicycle_stage_sequencer

Parametrised stage sequencer for the multi-cycle RISC datapath, and the successor to the fixed five-stage controller. It drives one-hot IF/ID/EX/MEM/WB enables and skips stages according to the instruction class decoded in ID. It stretches IF and MEM for memory wait states, with a configurable timeout, and supports stall, halt-at-boundary and a retired-instruction counter. It sits beside the main control unit and feeds the stage enables, the PC-register write enable and debug status.

## Interface
Parameters:
- TIMEOUT, 16, maximum consecutive not-ready cycles in IF or MEM before bus error; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op_class  in  3  instruction class from the decoder, valid during ID. Codes: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5–7 illegal.
- imem_ready  in  1  instruction memory data valid this cycle.
- dmem_ready  in  1  data memory access complete this cycle.
- stall  in  1  freezes the sequencer.
- halt_req  in  1  stop at the next instruction boundary.
- en_if, en_id, en_ex, en_mem, en_wb  out  1 each  stage enables, at most one high.
- stage_num  out  3  0 IF, 1 ID, 2 EX, 3 MEM, 4 WB, 7 HALT.
- pc_wr  out  1  PC register write, final cycle of each instruction.
- retire  out  1  same timing as pc_wr.
- illegal  out  1  pulse in the ID cycle of an illegal class.
- bus_err  out  1  sticky timeout flag.
- halted  out  1  high in HALT.
- instr_count  out  CNT_W  retired instructions, wraps at 2^CNT_W.

## Operation
- The FSM states are S_IF, S_ID, S_EX, S_MEM, S_WB and S_HALT. Enables, stage_num and halted are Moore decodes of the state.
- Class-dependent paths:
  - ALU: IF→ID→EX→WB.
  - LOAD: IF→ID→EX→MEM→WB.
  - STORE: IF→ID→EX→MEM.
  - BRANCH: IF→ID→EX.
  - JUMP: IF→ID.
  - Illegal: IF→ID, and the instruction is treated as a no-op retire.
- op_class is registered at the end of the ID cycle into cls_q. The EX, MEM and WB transitions use cls_q only.
- An instruction's last stage is WB (ALU, LOAD), MEM (STORE), EX (BRANCH) or ID (JUMP, illegal).
- In the last stage's completing cycle, pc_wr and retire are high for one cycle. On the next edge instr_count increments and the FSM goes to S_IF, or to S_HALT if halt_req is high in that cycle.
- IF completes only in a cycle with imem_ready=1.
- MEM completes only in a cycle with dmem_ready=1.
- ID, EX and WB always complete in one cycle.
- Wait counter:
  - Counts consecutive not-ready cycles in IF or MEM and clears on any stage change.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT with ready still low, the next state is S_HALT and bus_err is set.
- S_HALT is left only by rst. bus_err clears only on rst.
- stall=1:
  - All enables, pc_wr, retire and illegal are forced to 0.
  - The state, wait counter, cls_q and instr_count hold.
  - Ready inputs are ignored.
- Priority: rst > stall > timeout > normal transition.
- When halt_req and completion coincide with a timeout, the timeout wins: bus_err=1.

## Timing
- Reset values: state S_IF, cls_q 0, wait counter 0, instr_count 0, bus_err 0.
- All enables and pulses are forced to 0 while rst=1.
- The first en_if cycle is the first cycle after rst deasserts.
- Latency with zero wait states: ALU 4, LOAD 5, STORE 4, BRANCH 3, JUMP 2 cycles from the IF start to the next IF start.
- Each not-ready cycle in IF or MEM adds one cycle.
- With TIMEOUT=N, an access that is never ready spends N+1 cycles in the stage. S_HALT is entered on the following edge, and bus_err is visible from that cycle.
- rst asserted mid-instruction: S_IF on the next edge, with no retire for the aborted instruction.
- instr_count at 2^CNT_W−1 plus one retire becomes 0.

## Structure
- Package seq_pkg: state enum, op_class codes, stage_num encodings.
- Sub-module seq_wait_timer: holds the wait counter and TIMEOUT compare, with inputs clear, count and hold, and output expired.
- The top holds the FSM, cls_q, output decode and counter.

## Test plan
- ALU, LOAD, STORE, BRANCH, JUMP in sequence, readies tied high → stage_num sequences 0-1-2-4, 0-1-2-3-4, 0-1-2-3, 0-1-2, 0-1; five retire pulses; instr_count=5 after 18 cycles.
- LOAD with dmem_ready low 3 cycles, TIMEOUT=16 → 4 MEM cycles, total 8 cycles, no bus_err.
- TIMEOUT=4, imem_ready held low → 5 IF cycles, then stage_num=7, bus_err=1, halted=1; stays halted until rst.
- stall high 2 cycles during EX of ALU → enables 0 for 2 cycles, EX resumes, retire 2 cycles late.
- halt_req high during BRANCH EX → retire pulses, then S_HALT with bus_err=0. op_class=6 → illegal pulse in ID, retire, back to IF.
- CNT_W=4, 17 JUMP instructions → instr_count wraps to 1. rst during MEM of LOAD → IF next cycle, count unchanged.
